// File: rtl/maxpool_relu_2x2_pkg.sv
// maxpool_relu_2x2_pkg: shared CNN layer constants and pooling phase encoding
package maxpool_relu_2x2_pkg;
  localparam int CNN_DATA_W = 21;
  localparam int CNN_CNT_W  = 5;
  typedef enum logic [1:0] {
    PH_LOAD_P = 2'b00,
    PH_WR_BUF = 2'b01,
    PH_MERGE  = 2'b10,
    PH_EMIT   = 2'b11
  } phase_e;
endpackage

// File: rtl/pool_line_buffer.sv
// pool_line_buffer: one pooled row of partial maxima with per-entry valid bits
module pool_line_buffer
  import maxpool_relu_2x2_pkg::*;
#(
  parameter int DATA_W = CNN_DATA_W,
  parameter int DEPTH  = 16,
  parameter int AW     = CNN_CNT_W - 1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              wr_en_i,
  input  logic [AW-1:0]     wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic              wr_valid_i,
  input  logic [AW-1:0]     rd_addr_i,
  output logic [DATA_W-1:0] rd_data_o,
  output logic              rd_valid_o
);
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [DEPTH-1:0]  valid_q, valid_d;
  // data words carry no reset; only the valid bits gate their use
  always_ff @(posedge clk_i) begin
    if (wr_en_i) data_q[wr_addr_i] <= wr_data_i;
  end
  // the write port both sets (even row) and clears (consumed) an entry's valid bit
  always_comb begin
    valid_d = valid_q;
    if (wr_en_i) valid_d[wr_addr_i] = wr_valid_i;
  end
  // valid bit register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) valid_q <= '0;
    else         valid_q <= valid_d;
  end
  assign rd_data_o  = data_q[rd_addr_i];
  assign rd_valid_o = valid_q[rd_addr_i];
endmodule

// File: rtl/maxpool_relu_2x2.sv
// maxpool_relu_2x2: streaming ReLU followed by 2x2 max pooling over a raster
module maxpool_relu_2x2
  import maxpool_relu_2x2_pkg::*;
#(
  parameter int DATA_W = CNN_DATA_W,
  parameter int LINE_W = 32
) (
  input  logic                        clk_in,
  input  logic                        rst_in,
  input  logic                        data_valid_in,
  input  logic signed [DATA_W-1:0]    pixel_data_in,
  input  logic [CNN_CNT_W-1:0]        hcount_in,
  input  logic [CNN_CNT_W-1:0]        vcount_in,
  output logic                        data_valid_out,
  output logic signed [DATA_W-1:0]    pixel_data_out,
  output logic [CNN_CNT_W-1:0]        hcount_out,
  output logic [CNN_CNT_W-1:0]        vcount_out
);
  localparam int DEPTH = LINE_W / 2;
  localparam int AW = CNN_CNT_W - 1;
  localparam logic [CNN_CNT_W:0] H_LIMIT = (CNN_CNT_W + 1)'(2 * DEPTH);
  logic [DATA_W-1:0] relu, p_max, b_max, p_q, p_d, rd_data;
  logic              rd_valid, accept, wr_en, wr_valid, emit;
  phase_e            phase;
  // rectify, pairwise max and per-pixel role; an odd trailing column is never accepted
  always_comb begin
    relu     = pixel_data_in[DATA_W-1] ? '0 : pixel_data_in;
    p_max    = (p_q > relu) ? p_q : relu;
    b_max    = (rd_data > relu) ? rd_data : relu;
    accept   = data_valid_in && ({1'b0, hcount_in} < H_LIMIT);
    phase    = phase_e'({vcount_in[0], hcount_in[0]});
    emit     = accept && phase == PH_EMIT && rd_valid;
    wr_en    = accept && (phase == PH_WR_BUF || emit);
    wr_valid = phase == PH_WR_BUF;
    p_d      = (accept && phase == PH_LOAD_P) ? relu :
               (accept && phase == PH_MERGE)  ? b_max : p_q;
  end
  pool_line_buffer #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (AW)
  ) u_buf (
    .clk_i      (clk_in),
    .rst_ni     (rst_in),
    .wr_en_i    (wr_en),
    .wr_addr_i  (hcount_in[CNN_CNT_W-1:1]),
    .wr_data_i  (p_max),
    .wr_valid_i (wr_valid),
    .rd_addr_i  (hcount_in[CNN_CNT_W-1:1]),
    .rd_data_o  (rd_data),
    .rd_valid_o (rd_valid)
  );
  // pair register and output registers; outputs hold between pulses
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      p_q            <= '0;
      data_valid_out <= 1'b0;
      pixel_data_out <= '0;
      hcount_out     <= '0;
      vcount_out     <= '0;
    end else begin
      p_q            <= p_d;
      data_valid_out <= emit;
      if (emit) begin
        pixel_data_out <= p_max;
        hcount_out     <= {1'b0, hcount_in[CNN_CNT_W-1:1]};
        vcount_out     <= {1'b0, vcount_in[CNN_CNT_W-1:1]};
      end
    end
  end
endmodule

// File: tb/tb_maxpool_relu_2x2.sv
// tb_maxpool_relu_2x2: random and directed raster checks against a window model
module tb_maxpool_relu_2x2;
  logic clk = 1'b0;
  logic rst_in = 1'b0;
  logic data_valid_in = 1'b0;
  logic signed [20:0] pixel_data_in = '0;
  logic [4:0] hcount_in = '0, vcount_in = '0;
  logic dv [2];
  logic signed [20:0] po [2];
  logic [4:0] ho [2], vo [2];
  int total = 0, bad = 0;
  int ev [2][32], od [2][32];
  bit vld [2][16];
  bit exp_v [2];
  int hold_pix [2], hold_h [2], hold_v [2], pulses [2];

  always #5 clk = ~clk;

  maxpool_relu_2x2 #(.DATA_W(21), .LINE_W(32)) u32 (
    .clk_in(clk), .rst_in(rst_in), .data_valid_in(data_valid_in),
    .pixel_data_in(pixel_data_in), .hcount_in(hcount_in), .vcount_in(vcount_in),
    .data_valid_out(dv[0]), .pixel_data_out(po[0]), .hcount_out(ho[0]), .vcount_out(vo[0]));
  maxpool_relu_2x2 #(.DATA_W(21), .LINE_W(31)) u31 (
    .clk_in(clk), .rst_in(rst_in), .data_valid_in(data_valid_in),
    .pixel_data_in(pixel_data_in), .hcount_in(hcount_in), .vcount_in(vcount_in),
    .data_valid_out(dv[1]), .pixel_data_out(po[1]), .hcount_out(ho[1]), .vcount_out(vo[1]));

  function automatic int mx(int a, int b);
    return a > b ? a : b;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic check_outs();
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("d%0d_valid", d), {31'b0, dv[d]}, {31'b0, exp_v[d]});
      chk($sformatf("d%0d_pixel", d), po[d], hold_pix[d]);
      chk($sformatf("d%0d_hcount", d), {27'b0, ho[d]}, hold_h[d]);
      chk($sformatf("d%0d_vcount", d), {27'b0, vo[d]}, hold_v[d]);
      if (dv[d]) pulses[d]++;
    end
  endtask

  task automatic step(bit vl, int h, int v, int pix);
    int r, lim;
    @(negedge clk);
    data_valid_in = vl;
    hcount_in = h[4:0];
    vcount_in = v[4:0];
    pixel_data_in = pix[20:0];
    for (int d = 0; d < 2; d++) begin
      exp_v[d] = 1'b0;
      lim = (d == 0) ? 32 : 30;
      if (vl && h < lim) begin
        r = pix < 0 ? 0 : pix;
        if (v % 2 == 0) begin
          ev[d][h] = r;
          if (h % 2 == 1) vld[d][h/2] = 1'b1;
        end else begin
          od[d][h] = r;
          if (h % 2 == 1 && vld[d][h/2]) begin
            vld[d][h/2] = 1'b0;
            exp_v[d] = 1'b1;
            hold_pix[d] = mx(mx(ev[d][h-1], ev[d][h]), mx(od[d][h-1], od[d][h]));
            hold_h[d] = h / 2;
            hold_v[d] = v / 2;
          end
        end
      end
    end
    @(posedge clk);
    #1;
    check_outs();
  endtask

  task automatic idle();
    step(1'b0, int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
         int'($urandom_range(0, 2000)) - 1000);
  endtask

  task automatic do_reset(int cycles);
    @(negedge clk);
    rst_in = 1'b0;
    data_valid_in = 1'b0;
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 16; i++) vld[d][i] = 1'b0;
      exp_v[d] = 1'b0;
      hold_pix[d] = 0;
      hold_h[d] = 0;
      hold_v[d] = 0;
    end
    repeat (cycles) @(posedge clk);
    #1;
    check_outs();
    @(negedge clk);
    rst_in = 1'b1;
  endtask

  task automatic row(int v, bit gaps);
    for (int h = 0; h < 32; h++) begin
      step(1'b1, h, v, (h == 30) ? 1000 : int'($urandom_range(0, 1499)) - 500);
      if (gaps) repeat ($urandom_range(0, 2)) idle();
    end
  endtask

  initial begin
    int base0, base1;
    do_reset(3);
    // small 2x2 window: max is 9 at pooled (0,0), one cycle after row1 h1
    step(1'b1, 0, 0, 5);
    step(1'b1, 1, 0, -3);
    step(1'b1, 0, 1, 2);
    step(1'b1, 1, 1, 9);
    chk("w1_pulse", {31'b0, dv[0]}, 32'd1);
    chk("w1_pixel", po[0], 32'd9);
    idle();
    chk("w1_single", {31'b0, dv[0]}, 32'd0);
    // all-negative window rectifies to zero
    step(1'b1, 2, 2, -1);
    step(1'b1, 3, 2, -7);
    step(1'b1, 2, 3, -2);
    step(1'b1, 3, 3, -100);
    chk("neg_pixel", po[0], 32'd0);
    chk("neg_hcount", {27'b0, ho[0]}, 32'd1);
    // one even row followed by a repeated odd row
    base0 = pulses[0];
    for (int h = 0; h < 4; h++) step(1'b1, h, 4, int'($urandom_range(0, 999)));
    for (int h = 0; h < 4; h++) step(1'b1, h, 5, int'($urandom_range(0, 999)));
    chk("rep_first", pulses[0] - base0, 32'd2);
    for (int h = 0; h < 4; h++) step(1'b1, h, 5, int'($urandom_range(0, 999)));
    chk("rep_second", pulses[0] - base0, 32'd2);
    // reset mid-frame after row 6 h0-h3
    for (int h = 0; h < 4; h++) step(1'b1, h, 6, int'($urandom_range(0, 999)));
    do_reset(2);
    base0 = pulses[0];
    for (int h = 0; h < 4; h++) step(1'b1, h, 7, int'($urandom_range(0, 999)));
    chk("rst_no_out", pulses[0] - base0, 32'd0);
    row(8, 1'b0);
    row(9, 1'b0);
    chk("rst_next_pair", pulses[0] - base0, 32'd16);
    // full random frame with gaps
    base0 = pulses[0];
    base1 = pulses[1];
    for (int v = 0; v < 32; v++) row(v, 1'b1);
    chk("frame_pulses32", pulses[0] - base0, 32'd256);
    chk("frame_pulses31", pulses[1] - base1, 32'd240);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
